// File: rtl/gdsp_tx_scheduler.sv
// Frame sequencer for the 16-QAM TX chain: sample/symbol strobes, FIR clear/fill/drain, AWGN magnitude.
// Optional macro GDSP_NOISE_RAMP_EN: noise_mag ramps 1 LSB per symbol instead of loading at frame start.
module gdsp_tx_scheduler #(
  parameter int CLK_DIV         = 27,
  parameter int SPS             = 4,
  parameter int NUM_TAPS        = 7,
  parameter int FRAME_SYMS      = 1024,
  parameter int NOISE_MAG_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       cont,
  input  logic [NOISE_MAG_WIDTH-1:0] noise_mag_target,
  output logic                       sample_en,
  output logic                       sym_en,
  output logic                       fir_clr,
  output logic                       zero_ins,
  output logic                       out_valid,
  output logic                       busy,
  output logic [1:0]                 state,
  output logic [15:0]                sym_cnt,
  output logic                       frame_done,
  output logic [NOISE_MAG_WIDTH-1:0] noise_mag
);

  typedef enum logic [1:0] {IDLE = 2'd0, CLR = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_t;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PH_W  = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int TAP_W = $clog2(NUM_TAPS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(SPS - 1);
  localparam logic [TAP_W-1:0] TAP_LAST   = TAP_W'(NUM_TAPS - 1);
  localparam logic [TAP_W-1:0] TAP_FULL   = TAP_W'(NUM_TAPS);
  localparam logic [15:0]      FRAME_LAST = 16'(FRAME_SYMS);

  state_t                     st_q, st_d;
  logic [DIV_W-1:0]           div_q, div_d;
  logic [PH_W-1:0]            ph_q, ph_d;
  logic [TAP_W-1:0]           fill_q, fill_d, drn_q, drn_d;
  logic                       stop_lat_q, stop_lat_d;
  logic                       restart;
  logic                       sample_d, sym_d, fir_clr_d, zero_ins_d, out_valid_d, frame_done_d;
  logic [15:0]                sym_cnt_d;
  logic [NOISE_MAG_WIDTH-1:0] noise_d;

  assign state = st_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    st_d         = st_q;
    div_d        = div_q;
    ph_d         = ph_q;
    fill_d       = fill_q;
    drn_d        = drn_q;
    stop_lat_d   = stop_lat_q;
    sym_cnt_d    = sym_cnt;
    noise_d      = noise_mag;
    zero_ins_d   = zero_ins;
    out_valid_d  = out_valid;
    fir_clr_d    = 1'b0;
    frame_done_d = 1'b0;
    restart      = 1'b0;

    unique case (st_q)
      IDLE: begin
        if (start) begin
          st_d      = CLR;
          fir_clr_d = 1'b1;
          sym_cnt_d = '0;
          ph_d      = '0;
          fill_d    = '0;
`ifndef GDSP_NOISE_RAMP_EN
          noise_d   = noise_mag_target;
`endif
        end
      end
      CLR: st_d = RUN;
      RUN: begin
        if (stop) stop_lat_d = 1'b1;
        if (sample_en && ph_q == PH_LAST && (sym_cnt == FRAME_LAST || stop_lat_q)) begin
          st_d  = DRAIN;
          drn_d = '0;
        end
      end
      DRAIN: begin
        if (stop) stop_lat_d = 1'b1;
        if (sample_en) begin
          if (drn_q == TAP_LAST) begin
            frame_done_d = 1'b1;
            // A stop arriving on the final drain strobe still cancels the restart.
            if (cont && !stop_lat_q && !stop) begin
              st_d      = RUN;
              restart   = 1'b1;
              sym_cnt_d = '0;
`ifndef GDSP_NOISE_RAMP_EN
              noise_d   = noise_mag_target;
`endif
            end else begin
              st_d = IDLE;
            end
          end else begin
            drn_d = drn_q + 1'b1;
          end
        end
      end
      default: st_d = IDLE;
    endcase

    // Phase and fill count advance once each strobe cycle has been consumed.
    if (sample_en && st_q != IDLE) begin
      ph_d = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
      if (fill_q != TAP_FULL) fill_d = fill_q + 1'b1;
      if (fill_q == TAP_LAST) out_valid_d = 1'b1;
    end
    if (restart) ph_d = '0;

    if (st_q == IDLE || st_d == IDLE || restart) div_d = '0;
    else div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;

    // A back-to-back restart emits its first strobe immediately and realigns the divider.
    sample_d = (st_d != IDLE) && (restart || (st_q != IDLE && div_q == DIV_LAST));
    sym_d    = sample_d && st_d == RUN && ph_d == '0;
    if (sym_d && sym_cnt_d != FRAME_LAST) sym_cnt_d = sym_cnt_d + 16'd1;

`ifdef GDSP_NOISE_RAMP_EN
    if (sym_d) begin
      if (noise_mag < noise_mag_target)      noise_d = noise_mag + 1'b1;
      else if (noise_mag > noise_mag_target) noise_d = noise_mag - 1'b1;
    end
`endif

    if (st_d != DRAIN) zero_ins_d = 1'b0;
    else if (sample_d) zero_ins_d = 1'b1;

    if (st_d == IDLE) begin
      stop_lat_d  = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= IDLE;
      div_q      <= '0;
      ph_q       <= '0;
      fill_q     <= '0;
      drn_q      <= '0;
      stop_lat_q <= 1'b0;
      sample_en  <= 1'b0;
      sym_en     <= 1'b0;
      fir_clr    <= 1'b0;
      zero_ins   <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      sym_cnt    <= '0;
      frame_done <= 1'b0;
      noise_mag  <= '0;
    end else begin
      st_q       <= st_d;
      div_q      <= div_d;
      ph_q       <= ph_d;
      fill_q     <= fill_d;
      drn_q      <= drn_d;
      stop_lat_q <= stop_lat_d;
      sample_en  <= sample_d;
      sym_en     <= sym_d;
      fir_clr    <= fir_clr_d;
      zero_ins   <= zero_ins_d;
      out_valid  <= out_valid_d;
      busy       <= (st_d != IDLE);
      sym_cnt    <= sym_cnt_d;
      frame_done <= frame_done_d;
      noise_mag  <= noise_d;
    end
  end

endmodule

// File: doc/gdsp_tx_scheduler.md
Name: gdsp_tx_scheduler

Overview:
Frame-level sequencer for the 16-QAM TX/channel chain. It derives the sample-rate strobe from the 27 MHz system clock and issues symbol strobes every SPS samples. It clears, fills and drains the RRC FIR, flags valid output and programs the AWGN noise magnitude. It sits between the control/register interface and the LFSR, mapper, RRC FIR and noise generator.

Parameters:
CLK_DIV, 27, system clocks per sample strobe (>=1); 27 gives 1 MS/s
SPS, 4, samples per symbol (>=1)
NUM_TAPS, 7, FIR length; sets fill and drain length in sample strobes
FRAME_SYMS, 1024, symbols per frame (1..65535)
NOISE_MAG_WIDTH, 8, noise magnitude register width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  pulse; begin frame (honoured only in IDLE)
stop  in  1  pulse; end frame early at next symbol boundary
cont  in  1  level; restart the next frame back-to-back
noise_mag_target  in  NOISE_MAG_WIDTH  requested noise magnitude (unsigned)
sample_en  out  1  one-cycle sample strobe to FIR/noise/DAC path
sym_en  out  1  one-cycle strobe: advance LFSR by BITS_PER_SYM, mapper loads symbol
fir_clr  out  1  one-cycle synchronous clear of the FIR delay line
zero_ins  out  1  mapper forces output to 0 (drain)
out_valid  out  1  FIR output meaningful
busy  out  1  state != IDLE
state  out  2  0=IDLE 1=CLR 2=RUN 3=DRAIN
sym_cnt  out  16  symbols issued in current frame
frame_done  out  1  one-cycle pulse at frame end
noise_mag  out  NOISE_MAG_WIDTH  magnitude to AWGN generator

Behaviour:
- Reset: every output 0, state IDLE, internal counters 0, stop latch cleared.
- All outputs are registered. Cycle n means the state after rising edge n.
- IDLE: div/phase counters held at 0. On start sampled at edge t: state=CLR in cycle t+1 with fir_clr=1, sym_cnt=0. stop is ignored in IDLE; start+stop together in IDLE starts the frame.
- CLR lasts exactly 1 cycle, then RUN. Divider div_cnt runs 0..CLK_DIV-1 in CLR/RUN/DRAIN. sample_en is high when the wrap occurs.
  - First sample_en is in cycle t+1+CLK_DIV; subsequent strobes every CLK_DIV cycles.
  - CLK_DIV=1 gives sample_en every active cycle.
- Phase ph 0..SPS-1 advances on each sample_en. In RUN, sym_en is coincident with sample_en when ph==0, and sym_cnt increments with it.
- Fill: out_valid rises the cycle after the NUM_TAPS-th sample_en of a frame.
- RUN->DRAIN occurs on the sample_en with ph==SPS-1 when either sym_cnt==FRAME_SYMS or the stop latch is set.
- stop during RUN sets the stop latch. The latch clears on entry to IDLE.
- DRAIN: zero_ins=1 and sym_en=0 for NUM_TAPS sample strobes. On the last drain strobe:
  - frame_done pulses in the next cycle.
  - If cont=1 and no stop is latched, the block goes to RUN with sym_cnt=0, ph=0, no fir_clr, and out_valid held high.
  - Otherwise the next state is IDLE, and out_valid and zero_ins fall in the same cycle frame_done pulses.
- stop during DRAIN only cancels the cont restart. start outside IDLE is ignored.
- sym_cnt saturates at FRAME_SYMS. It holds its value in IDLE until the next start.
- noise_mag is unsigned. Transfer rule is per the optional feature below; it never overshoots the target.
- Async rst mid-frame returns immediately to reset values. No frame_done is issued.

Optional Feature:
GDSP_NOISE_RAMP_EN
- Defined: on each sym_en, noise_mag steps 1 LSB toward the current noise_mag_target and holds when equal. This avoids SNR steps mid-frame during BER sweeps.
- Undefined: noise_mag loads noise_mag_target in the CLR cycle and during the cont restart cycle only, and is frozen otherwise.

Test Plan:
- CLK_DIV=3, SPS=4, NUM_TAPS=7, FRAME_SYMS=4; start at edge 0 -> fir_clr cycle 1 only; expected strobes and outputs:
  - sample_en cycles 4,7,...,70 (23 strobes);
  - sym_en cycles 4,16,28,40;
  - zero_ins cycles 52..70;
  - out_valid cycles 23..70;
  - frame_done cycle 71; state IDLE cycle 71.
- Same config; stop at cycle 20 -> DRAIN entered after strobe at cycle 25 (ph=3); sym_cnt=2; 7 drain strobes; frame_done cycle 47.
- cont=1 held, FRAME_SYMS=4 -> second frame's sym_en at cycle 71 with no fir_clr; out_valid never drops; stop then ends after the current frame.
- Reset asserted at cycle 30 mid-RUN -> all outputs 0 immediately; start ignored while rst=1; clean frame after release.
- noise_mag_target=10, GDSP_NOISE_RAMP_EN defined, FRAME_SYMS=16 -> noise_mag 1..10 on successive sym_en, holds at 10; target lowered to 8 -> steps down to 8. Undefined -> noise_mag=10 from CLR cycle.
- start pulsed during RUN, start+stop together in IDLE -> first ignored; second starts the frame normally.
